// File: rtl/psum_scatter_accum.sv
// psum_scatter_accum
//
// Scatter-accumulates 16-lane product beats into an out_size x out_size
// partial-sum array. At the end of a tile it drains the array in raster order.
//
// Flow:
//   IDLE  : in_ready=1. An accepted beat is latched into the lane buffer.
//   ACCUM : one lane per cycle, lane 0 first. Each lane is a saturating add
//           into acc[row][col]. Out-of-range lanes are dropped.
//   DRAIN : row-major valid/ready stream. Each entry is cleared as it is read.
//           out_last marks (out_size-1, out_size-1).
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   in_valid/ready beat handshake; in_last tags the final beat of a tile
//   data_in        lanes x signed word_length products
//   data_in_rows   lanes x col_length output row per lane
//   data_in_cols   lanes x col_length output column per lane
//   out_valid/ready drain handshake
//   out_data       signed acc_width accumulated value
//   out_row/col    raster coordinate of out_data
//   out_last       final element of the drain
//   busy           high in ACCUM or DRAIN
//
// Build option:
//   SKIP_ZERO_LANE_EN - ACCUM skips zero-valued lanes. A beat of all zeros
//   takes a single cycle. Results are unchanged; only timing differs.

module psum_scatter_accum #(
   parameter int unsigned col_length  = 8,
   parameter int unsigned word_length = 8,
   parameter int unsigned acc_width   = 20,
   parameter int unsigned lanes       = 16,
   parameter int unsigned out_size    = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic [lanes*word_length-1:0]  data_in,
   input  logic [lanes*col_length-1:0]   data_in_cols,
   input  logic [lanes*col_length-1:0]   data_in_rows,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [acc_width-1:0]          out_data,
   output logic [col_length-1:0]         out_row,
   output logic [col_length-1:0]         out_col,
   output logic                          out_last,
   output logic                          busy
);

   localparam int unsigned Cells = out_size * out_size;
   localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
   localparam int unsigned LaneW = (lanes > 1) ? $clog2(lanes) : 1;

   localparam logic [IdxW-1:0]       LastIdx = IdxW'(Cells - 1);
   localparam logic [IdxW-1:0]       SizeIdx = IdxW'(out_size);
   localparam logic [col_length-1:0] SizeC   = col_length'(out_size);
   localparam logic [col_length-1:0] EdgeC   = col_length'(out_size - 1);
   localparam logic [acc_width-1:0]  AccMax  = {1'b0, {(acc_width - 1){1'b1}}};
   localparam logic [acc_width-1:0]  AccMin  = {1'b1, {(acc_width - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                        state_q, state_d;
   logic [LaneW-1:0]              lane_idx_q, lane_idx_d;
   logic                          last_q;
   logic [lanes*word_length-1:0]  val_buf_q;
   logic [lanes*col_length-1:0]   row_buf_q;
   logic [lanes*col_length-1:0]   col_buf_q;
   logic [acc_width-1:0]          acc_q [Cells];
   logic [IdxW-1:0]               drain_idx_q, drain_idx_d;
   logic [col_length-1:0]         drain_row_d, drain_col_d;
   logic [acc_width-1:0]          out_data_d;
   logic                          out_last_d;
   logic                          load_beat;

   // ------------------------------------------------------------------
   // Lane buffer unpacking
   // ------------------------------------------------------------------
   logic [word_length-1:0] lane_val [lanes];
   logic [col_length-1:0]  lane_row [lanes];
   logic [col_length-1:0]  lane_col [lanes];

   always_comb begin
      for (int i = 0; i < lanes; i++) begin
         lane_val[i] = val_buf_q[i*word_length +: word_length];
         lane_row[i] = row_buf_q[i*col_length +: col_length];
         lane_col[i] = col_buf_q[i*col_length +: col_length];
      end
   end

   // ------------------------------------------------------------------
   // Lane selection
   //   sel        lane processed this ACCUM cycle
   //   lane_act   sel holds a real lane (false only for an all-zero remainder)
   //   accum_done no lanes remain after this cycle
   // ------------------------------------------------------------------
   logic [LaneW-1:0] sel;
   logic             lane_act;
   logic             accum_done;

`ifdef SKIP_ZERO_LANE_EN
   logic [lanes-1:0] pend;
   logic [lanes-1:0] rest;

   // Pick the lowest nonzero lane at or above lane_idx. The beat finishes in
   // the same cycle as its last nonzero lane, so an all-zero beat costs one cycle.
   always_comb begin
      pend = '0;
      for (int i = 0; i < lanes; i++) begin
         pend[i] = (lane_val[i] != '0) && (i >= int'(lane_idx_q));
      end
      sel = '0;
      for (int i = lanes - 1; i >= 0; i--) begin
         if (pend[i]) sel = LaneW'(i);
      end
      lane_act   = |pend;
      rest       = pend;
      rest[sel]  = 1'b0;
      accum_done = ~|rest;
   end
`else
   always_comb begin
      sel        = lane_idx_q;
      lane_act   = 1'b1;
      accum_done = (lane_idx_q == LaneW'(lanes - 1));
   end
`endif

   // ------------------------------------------------------------------
   // Saturating accumulate datapath for the selected lane
   // ------------------------------------------------------------------
   logic [col_length-1:0] cur_row, cur_col;
   logic                  in_range;
   logic [IdxW-1:0]       acc_addr;
   logic [acc_width:0]    acc_ext, val_ext, sum;
   logic [acc_width-1:0]  sat_val;

   always_comb begin
      cur_row  = lane_row[sel];
      cur_col  = lane_col[sel];
      in_range = (cur_row < SizeC) && (cur_col < SizeC);
      // Only meaningful when in_range; out-of-range lanes never write.
      acc_addr = IdxW'(cur_row) * SizeIdx + IdxW'(cur_col);
      acc_ext  = {acc_q[acc_addr][acc_width-1], acc_q[acc_addr]};
      val_ext  = {{(acc_width + 1 - word_length){lane_val[sel][word_length-1]}}, lane_val[sel]};
      sum      = acc_ext + val_ext;
      // Overflow when the two top bits disagree; the top bit is the true sign.
      if (sum[acc_width] != sum[acc_width-1]) begin
         sat_val = sum[acc_width] ? AccMin : AccMax;
      end else begin
         sat_val = sum[acc_width-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. The array has a single write port, shared by the
   // ACCUM add and the DRAIN clear; these never happen in the same cycle.
   // ------------------------------------------------------------------
   logic                 we;
   logic [IdxW-1:0]      waddr;
   logic [acc_width-1:0] wdata;

   always_comb begin
      state_d     = state_q;
      lane_idx_d  = lane_idx_q;
      drain_idx_d = drain_idx_q;
      drain_row_d = out_row;
      drain_col_d = out_col;
      load_beat   = 1'b0;
      we          = 1'b0;
      waddr       = '0;
      wdata       = '0;

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               load_beat  = 1'b1;
               lane_idx_d = '0;
               state_d    = StAccum;
            end
         end

         StAccum: begin
            if (lane_act && in_range) begin
               we    = 1'b1;
               waddr = acc_addr;
               wdata = sat_val;
            end
            lane_idx_d = sel + LaneW'(1);
            if (accum_done) begin
               lane_idx_d = '0;
               state_d    = last_q ? StDrain : StIdle;
            end
         end

         StDrain: begin
            if (out_ready) begin
               we    = 1'b1;
               waddr = drain_idx_q;
               wdata = '0;
               if (drain_idx_q == LastIdx) begin
                  drain_idx_d = '0;
                  drain_row_d = '0;
                  drain_col_d = '0;
                  state_d     = StIdle;
               end else begin
                  drain_idx_d = drain_idx_q + IdxW'(1);
                  if (out_col == EdgeC) begin
                     drain_col_d = '0;
                     drain_row_d = out_row + col_length'(1);
                  end else begin
                     drain_col_d = out_col + col_length'(1);
                  end
               end
            end
         end

         default: state_d = StIdle;
      endcase

      // Registered out_data is loaded from the post-write array contents, so
      // the final lane's add to entry 0 shows up as DRAIN begins.
      if (state_d == StDrain) begin
         out_data_d = (we && (waddr == drain_idx_d)) ? wdata : acc_q[drain_idx_d];
      end else begin
         out_data_d = '0;
      end
      out_last_d = (state_d == StDrain) && (drain_idx_d == LastIdx);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         lane_idx_q  <= '0;
         last_q      <= 1'b0;
         val_buf_q   <= '0;
         row_buf_q   <= '0;
         col_buf_q   <= '0;
         drain_idx_q <= '0;
         for (int i = 0; i < Cells; i++) begin
            acc_q[i] <= '0;
         end
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_row     <= '0;
         out_col     <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_idx_q  <= lane_idx_d;
         drain_idx_q <= drain_idx_d;
         if (load_beat) begin
            val_buf_q <= data_in;
            row_buf_q <= data_in_rows;
            col_buf_q <= data_in_cols;
            last_q    <= in_last;
         end
         if (we) begin
            acc_q[waddr] <= wdata;
         end
         in_ready  <= (state_d == StIdle);
         out_valid <= (state_d == StDrain);
         busy      <= (state_d != StIdle);
         out_data  <= out_data_d;
         out_row   <= drain_row_d;
         out_col   <= drain_col_d;
         out_last  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_psum_scatter_accum.sv
module tb_psum_scatter_accum;

   localparam int Lanes = 16;
   localparam int WL    = 8;
   localparam int CL    = 8;
   localparam int AW    = 20;
   localparam int N     = 11;
   localparam int Cells = N * N;
   localparam int AccMaxI = 524287;
   localparam int AccMinI = -524288;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  in_last = 1'b0;
   logic [Lanes*WL-1:0]   data_in = '0;
   logic [Lanes*CL-1:0]   data_in_cols = '0;
   logic [Lanes*CL-1:0]   data_in_rows = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [AW-1:0]         out_data;
   logic [CL-1:0]         out_row;
   logic [CL-1:0]         out_col;
   logic                  out_last;
   logic                  busy;

   psum_scatter_accum #(
      .col_length (CL),
      .word_length(WL),
      .acc_width  (AW),
      .lanes      (Lanes),
      .out_size   (N)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .data_in     (data_in),
      .data_in_cols(data_in_cols),
      .data_in_rows(data_in_rows),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int data;
      int row;
      int col;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   model [Cells];
   int   b_val [Lanes];
   int   b_row [Lanes];
   int   b_col [Lanes];

   function automatic int sat_add(input int a, input int b);
      int s;
      s = a + b;
      if (s > AccMaxI) return AccMaxI;
      if (s < AccMinI) return AccMinI;
      return s;
   endfunction

   // Expected ACCUM cycles for the beat in b_val.
   function automatic int exp_cycles();
`ifdef SKIP_ZERO_LANE_EN
      int nz;
      nz = 0;
      for (int i = 0; i < Lanes; i++) if (b_val[i] != 0) nz++;
      return (nz == 0) ? 1 : nz;
`else
      return Lanes;
`endif
   endfunction

   function automatic void model_beat(input bit last);
      for (int i = 0; i < Lanes; i++) begin
         if (b_row[i] >= 0 && b_row[i] < N && b_col[i] >= 0 && b_col[i] < N)
            model[b_row[i]*N + b_col[i]] = sat_add(model[b_row[i]*N + b_col[i]], b_val[i]);
      end
      if (last) begin
         for (int k = 0; k < Cells; k++) begin
            exp_t e;
            e.data = model[k];
            e.row  = k / N;
            e.col  = k % N;
            e.last = (k == Cells - 1);
            sb.push_back(e);
            model[k] = 0;
         end
      end
   endfunction

   function automatic void fill(input int val, input int row, input int col);
      for (int i = 0; i < Lanes; i++) begin
         b_val[i] = val;
         b_row[i] = row;
         b_col[i] = col;
      end
   endfunction

   // Drain monitor: every handshake is checked against the scoreboard front.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_out", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("out_data", longint'($signed(out_data)), e.data);
            check_eq("out_row", out_row, e.row);
            check_eq("out_col", out_col, e.col);
            check_eq("out_last", out_last, e.last);
         end
      end
   end

   // Called just after a negedge. Counts ACCUM cycles after the accept edge.
   task automatic send_beat(input bit last, input string tag);
      int cnt;
      for (int i = 0; i < Lanes; i++) begin
         logic [31:0] v, r, c;
         v = b_val[i];
         r = b_row[i];
         c = b_col[i];
         data_in[i*WL +: WL]      = v[WL-1:0];
         data_in_rows[i*CL +: CL] = r[CL-1:0];
         data_in_cols[i*CL +: CL] = c[CL-1:0];
      end
      in_valid = 1'b1;
      in_last  = last;
      cnt = 0;
      while (!in_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!in_ready) begin
         check_eq({tag, "_accept_timeout"}, in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_beat(last);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cnt = 0;
      if (!last) begin
         while (!in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
         end
         check_eq({tag, "_accum_cycles"}, cnt, exp_cycles());
      end else begin
         while (!out_valid && cnt < 100) begin
            cnt++;
            @(negedge clk);
         end
         check_eq({tag, "_drain_latency"}, cnt, exp_cycles());
      end
   endtask

   task automatic wait_drain(input string tag, input bit stall);
      int c;
      c = 0;
      while (sb.size() != 0 && c < 5000) begin
         @(posedge clk);
         #1;
         out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         c++;
      end
      out_ready = 1'b0;
      check_eq({tag, "_drained_left"}, sb.size(), 0);
      @(negedge clk);
      check_eq({tag, "_valid_after"}, out_valid, 0);
      check_eq({tag, "_ready_after"}, in_ready, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < Cells; k++) model[k] = 0;

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_row", out_row, 0);
      check_eq("rst_out_col", out_col, 0);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single beat: +5 at (2,3); other lanes nonzero but out of range.
      // Drain starts 16 edges after the accept edge (17 cycles counting the accept).
      fill(1, 15, 15);
      b_val[0] = 5; b_row[0] = 2; b_col[0] = 3;
      send_beat(1'b1, "single");
      check_eq("single_busy", busy, 1);
      wait_drain("single", 1'b0);

      // Collision: 16 lanes of -3 at (0,0) -> -48, random drain stalls
      fill(-3, 0, 0);
      send_beat(1'b1, "collide");
      wait_drain("collide", 1'b1);

      // Multi-beat plus an all-zero beat in the middle
      fill(0, 0, 0);
      b_val[0] = 7; b_row[0] = 1; b_col[0] = 1;
      send_beat(1'b0, "multi0");
      send_beat(1'b0, "multi1");
      fill(0, 3, 3);
      send_beat(1'b0, "zero_beat");
      fill(0, 0, 0);
      b_val[0] = 7; b_row[0] = 1; b_col[0] = 1;
      send_beat(1'b1, "multi2");
      wait_drain("multi", 1'b1);

      // in_last beat with every lane out of range still drains (all zeros)
      fill(9, 11, 0);
      for (int i = 8; i < Lanes; i++) begin
         b_row[i] = 0;
         b_col[i] = 11 + i;
      end
      send_beat(1'b1, "oor");
      wait_drain("oor", 1'b0);

      // Saturation both ways: +127 x8 at (4,4), -128 x8 at (5,5)
      for (int b = 0; b < 600; b++) begin
         for (int i = 0; i < Lanes; i++) begin
            b_val[i] = (i < 8) ? 127 : -128;
            b_row[i] = (i < 8) ? 4 : 5;
            b_col[i] = (i < 8) ? 4 : 5;
         end
         send_beat(b == 599, "sat");
      end
      wait_drain("sat", 1'b0);

      // Backpressure mid-drain, then reset while draining
      fill(0, 0, 0);
      b_val[0] = 11;  b_row[0] = 9;  b_col[0] = 4;
      b_val[1] = -20; b_row[1] = 10; b_col[1] = 10;
      b_val[2] = 3;   b_row[2] = 2;  b_col[2] = 2;
      send_beat(1'b1, "bp");
      begin
         int c;
         c = 0;
         while (sb.size() > 80 && c < 500) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            c++;
         end
         out_ready = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", longint'($signed(out_data)), sb[0].data);
            check_eq("stall_row", out_row, sb[0].row);
            check_eq("stall_col", out_col, sb[0].col);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_out_data", out_data, 0);
      rst = 1'b1;
      sb.delete();
      for (int k = 0; k < Cells; k++) model[k] = 0;
      @(negedge clk);

      // Fresh tile after reset: earlier entries (9,4),(10,10) must read zero
      fill(0, 0, 0);
      b_val[0] = 9; b_row[0] = 6; b_col[0] = 7;
      send_beat(1'b1, "post_rst");
      wait_drain("post_rst", 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_scatter_accum.md
Name: psum_scatter_accum

Overview:
Downstream of the sparse-conv PE. Consumes 16-lane product beats (value plus output row/col per lane) and scatter-adds each lane into an out_size x out_size partial-sum register array. At the end of a tile it streams the accumulated map out in raster order with a valid/ready handshake, clearing each entry as it is read.

Parameters:
col_length, 8, width of one row/col coordinate field
word_length, 8, width of one signed product lane
acc_width, 20, width of one signed accumulator
lanes, 16, product lanes per input beat
out_size, 11, output map side length (image_size + kernel_size - 1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
in_valid  input  1  product beat valid
in_ready  output  1  beat accepted when in_valid & in_ready
in_last  input  1  marks last beat of the tile
data_in  input  lanes*word_length  signed products; lane i = bits [(i+1)*word_length-1 -: word_length]
data_in_cols  input  lanes*col_length  per-lane output column, same slicing
data_in_rows  input  lanes*col_length  per-lane output row, same slicing
out_valid  output  1  drain element valid
out_ready  input  1  drain element consumed when out_valid & out_ready
out_data  output  acc_width  signed accumulated value
out_row  output  col_length  row of out_data
out_col  output  col_length  column of out_data
out_last  output  1  high with the final element (out_size-1, out_size-1)
busy  output  1  high in ACCUM or DRAIN

Behaviour:
- The clock port is clk and the reset port is rst. One clock. Reset is synchronous and active-low: when rst==0 at a clk edge, all state clears.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0. All accumulators=0, lane buffer empty, last flag=0.
- States:
  - IDLE: in_ready=1. On accept, latch the beat and in_last into the lane buffer, lane_idx=0, go to ACCUM.
  - ACCUM: one lane per cycle, lane 0 first; in_ready=0.
    - acc[row][col] += sign-extended value.
    - Lanes with row>=out_size or col>=out_size are dropped; the cycle is still consumed.
    - After lane lanes-1: if the latched last flag is set, go to DRAIN with index 0. Otherwise go to IDLE.
    - Throughput: one beat per lanes+1 cycles. Lanes hitting the same coordinate within or across beats sum correctly, because lanes are serialized.
  - DRAIN: out_valid=1 with acc at the current raster index (row-major); out_row/out_col reflect that index.
    - On out_ready, the entry is cleared to 0 and the index advances.
    - The element at index out_size*out_size-1 carries out_last=1. Its handshake returns the block to IDLE.
    - Outputs hold stable while out_valid & !out_ready.
- Arithmetic: signed saturating add to acc_width. Above 2^(acc_width-1)-1 clamps to the maximum; below -2^(acc_width-1) clamps to the minimum.
- Registered outputs; out_data is valid in the same cycle out_valid rises.
- Boundaries:
  - An in_last beat with all lanes out of range still triggers DRAIN.
  - in_valid during ACCUM or DRAIN is ignored; the source must hold it.
  - Reset mid-ACCUM or mid-DRAIN discards the partial tile and zeroes the array.
  - out_ready held low stalls indefinitely without data loss.

Optional Feature:
SKIP_ZERO_LANE_EN
- Defined: in ACCUM, lanes whose value is 0 are skipped. The next nonzero lane is processed in the same cycle the skip decision is made. A beat of all zeros takes 1 cycle. The DRAIN transition is unchanged.
- Undefined: every lane costs one cycle regardless of value. Results are identical either way; only cycle counts differ.

Test Plan:
- Reset then single beat: in_last=1, lane 0 = +5 at (2,3), all other lanes (15,15) -> after 17 cycles DRAIN starts. Index 2*11+3=25 outputs 5; all other 120 outputs 0; out_last on (10,10).
- Collision: one beat, all 16 lanes = -3 at (0,0), in_last=1 -> out_data at (0,0) = -48.
- Multi-beat: 3 beats of lane 0 = +7 at (1,1), last beat in_last=1 -> (1,1) = 21; in_ready low 16 cycles after each accept.
- Saturation: 9000 beats of 16 lanes = +127 at (4,4) -> (4,4) = 524287, no wrap.
- Backpressure and reset: out_ready low 10 cycles mid-drain -> outputs stable. Then rst=0 -> out_valid=0; next tile reads all zeros except new data.
- With SKIP_ZERO_LANE_EN: a beat of all zeros -> in_ready back high after 1 cycle (versus 16 without).
